// File: rtl/test_reg_wait_bank_if.sv
// Avalon-MM slave bundle for the test register bank.
interface test_reg_wait_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] avs_test_address;
  logic [DATA_W-1:0] avs_test_writedata;
  logic [BE_W-1:0]   avs_test_byteenable;
  logic              avs_test_write;
  logic              avs_test_read;
  logic [DATA_W-1:0] avs_test_readdata;
  logic              avs_test_waitrequest;

  // Fabric side drives requests.
  modport master (
    output avs_test_address,
    output avs_test_writedata,
    output avs_test_byteenable,
    output avs_test_write,
    output avs_test_read,
    input  avs_test_readdata,
    input  avs_test_waitrequest
  );

  // Test target side answers them.
  modport slave (
    input  avs_test_address,
    input  avs_test_writedata,
    input  avs_test_byteenable,
    input  avs_test_write,
    input  avs_test_read,
    output avs_test_readdata,
    output avs_test_waitrequest
  );

endinterface

// File: rtl/test_reg_wait_bank.sv
// Avalon-MM bus-exerciser target: byte-writable data registers, programmable
// wait states, write-invert / read-add-address transforms, access counter.
module test_reg_wait_bank #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned RESET_WAIT = 4
) (
  input  logic                  csi_MCLK_clk,
  input  logic                  rsi_MRST_reset_n,
  test_reg_wait_bank_if.slave   avs
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned WAIT_W   = 5;
  localparam int unsigned ACNT_W   = 16;
  localparam int unsigned CTRL_W   = 17;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] ACNT_ADDR = ADDR_W'(NUM_REGS + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // FSM state
  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wlat_q, wlat_d;

  // Register bank state
  logic [DATA_W-1:0]   dreg_q [NUM_REGS];
  logic [DATA_W-1:0]   dreg_d [NUM_REGS];
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                inv_q, inv_d;
  logic                adda_q, adda_d;
  logic                err_q, err_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;

  // Combinational bus-side signals
  logic                req_c;
  logic                waitreq_c;
  logic                done_c;
  logic                err_clr_c;
  logic [CTRL_W-1:0]   ctrl_rd_c;
  logic [DATA_W-1:0]   rdata_c;

  assign req_c = avs.avs_test_read | avs.avs_test_write;

  // The ERR clear bit only exists when the bus is wide enough to carry bit 16.
  if (DATA_W > 16) begin : g_err_clr
    assign err_clr_c = avs.avs_test_byteenable[2] & avs.avs_test_writedata[16];
  end else begin : g_no_err_clr
    assign err_clr_c = 1'b0;
  end

  assign ctrl_rd_c = {err_q, 6'b0, adda_q, inv_q, 3'b0, wait_q};

  // Wait-state FSM: WAIT is latched at request start so CTRL writes hit the next access.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wlat_d    = wlat_q;
    waitreq_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (wait_q == '0) begin
            done_c = 1'b1;
          end else begin
            waitreq_c = 1'b1;
            cnt_d     = WAIT_W'(1);
            wlat_d    = wait_q;
            state_d   = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (!req_c) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q < wlat_q) begin
          waitreq_c = 1'b1;
          cnt_d     = cnt_q + WAIT_W'(1);
        end else begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM registers
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wlat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wlat_q  <= wlat_d;
    end
  end

  // Register updates on completion; read+write together counts as a read and flags ERR.
  always_comb begin
    dreg_d = dreg_q;
    wait_d = wait_q;
    inv_d  = inv_q;
    adda_d = adda_q;
    err_d  = err_q;
    acnt_d = acnt_q;
    if (done_c) begin
      acnt_d = acnt_q + ACNT_W'(1);
      if (avs.avs_test_read) begin
        if (avs.avs_test_write) begin
          err_d = 1'b1;
        end
      end else if (avs.avs_test_write) begin
        for (int n = 0; n < NUM_REGS; n++) begin
          if (avs.avs_test_address == ADDR_W'(n)) begin
            for (int b = 0; b < BE_W; b++) begin
              if (avs.avs_test_byteenable[b]) begin
                dreg_d[n][8*b +: 8] = inv_q ? ~avs.avs_test_writedata[8*b +: 8]
                                            :  avs.avs_test_writedata[8*b +: 8];
              end
            end
          end
        end
        if (avs.avs_test_address == CTRL_ADDR) begin
          if (avs.avs_test_byteenable[0]) begin
            wait_d = avs.avs_test_writedata[WAIT_W-1:0];
          end
          if (avs.avs_test_byteenable[1]) begin
            inv_d  = avs.avs_test_writedata[8];
            adda_d = avs.avs_test_writedata[9];
          end
          if (err_clr_c) begin
            err_d = 1'b0;
          end
        end
      end
    end
  end

  // Bank registers
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        dreg_q[n] <= '0;
      end
      wait_q <= WAIT_W'(RESET_WAIT);
      inv_q  <= 1'b0;
      adda_q <= 1'b0;
      err_q  <= 1'b0;
      acnt_q <= '0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++) begin
        dreg_q[n] <= dreg_d[n];
      end
      wait_q <= wait_d;
      inv_q  <= inv_d;
      adda_q <= adda_d;
      err_q  <= err_d;
      acnt_q <= acnt_d;
    end
  end

  // Read mux: only drives data in the completion cycle of a read.
  always_comb begin
    rdata_c = '0;
    if (avs.avs_test_read && !waitreq_c) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (avs.avs_test_address == ADDR_W'(n)) begin
          rdata_c = adda_q ? dreg_q[n] + DATA_W'(avs.avs_test_address) : dreg_q[n];
        end
      end
      if (avs.avs_test_address == CTRL_ADDR) begin
        rdata_c = DATA_W'(ctrl_rd_c);
      end
      if (avs.avs_test_address == ACNT_ADDR) begin
        rdata_c = DATA_W'(acnt_q);
      end
    end
  end

  assign avs.avs_test_waitrequest = waitreq_c;
  assign avs.avs_test_readdata    = rdata_c;

endmodule

// File: tb/tb_test_reg_wait_bank.sv
// Directed bench for test_reg_wait_bank with hand-computed expectations.
module tb_test_reg_wait_bank;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam logic [5:0]  CTRL_A = 6'd8;
  localparam logic [5:0]  ACNT_A = 6'd9;
  localparam int          BOUND  = 200;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_acnt     = 0;

  always #5 clk = ~clk;

  test_reg_wait_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  test_reg_wait_bank #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(8), .RESET_WAIT(4)
  ) dut (
    .csi_MCLK_clk    (clk),
    .rsi_MRST_reset_n(rst_n),
    .avs             (bus.slave)
  );

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus access starting at posedge+1; returns data and stall cycles.
  task automatic xfer(input logic rd, input logic wr, input logic [5:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rdata, output int waits);
    bit done;
    bus.avs_test_address    = a;
    bus.avs_test_writedata  = d;
    bus.avs_test_byteenable = be;
    bus.avs_test_read       = rd;
    bus.avs_test_write      = wr;
    waits = 0;
    rdata = '0;
    done  = 1'b0;
    while (!done && waits <= BOUND) begin
      @(negedge clk);
      if (!bus.avs_test_waitrequest) begin
        rdata = bus.avs_test_readdata;
        done  = 1'b1;
      end else begin
        check("stall_rdata", bus.avs_test_readdata, 32'h0);
        waits++;
      end
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.avs_test_read  = 1'b0;
    bus.avs_test_write = 1'b0;
    if (done) exp_acnt = (exp_acnt + 1) % 65536;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a,
                        input logic [31:0] exp, input int exp_w);
    logic [31:0] r;
    int w;
    xfer(1'b1, 1'b0, a, 32'h0, 4'h0, r, w);
    check({tag, "_data"}, r, exp);
    check({tag, "_wait"}, 32'(w), 32'(exp_w));
  endtask

  task automatic wr_chk(input string tag, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int exp_w);
    logic [31:0] r;
    int w;
    xfer(1'b0, 1'b1, a, d, be, r, w);
    check({tag, "_wait"}, 32'(w), 32'(exp_w));
  endtask

  initial begin
    logic [31:0] r;
    int w;
    int hi_cnt;
    int n_hold;

    rst_n = 1'b0;
    bus.avs_test_address    = '0;
    bus.avs_test_writedata  = '0;
    bus.avs_test_byteenable = '0;
    bus.avs_test_read       = 1'b0;
    bus.avs_test_write      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_waitreq", 32'(bus.avs_test_waitrequest), 32'h0);
    check("rst_rdata", bus.avs_test_readdata, 32'h0);
    @(posedge clk);
    #1;

    // Reset WAIT=4: four stall cycles, then data
    rd_chk("rst_dreg0", 6'd0, 32'h0000_0000, 4);
    rd_chk("acnt_one", ACNT_A, 32'd1, 4);
    wr_chk("ctrl_wait0", CTRL_A, 32'h0000_0000, 4'hF, 4);
    rd_chk("ctrl_zero", CTRL_A, 32'h0000_0000, 0);

    // Byte-lane steering
    wr_chk("dreg2_full", 6'd2, 32'hA5A5_A5A5, 4'hF, 0);
    wr_chk("dreg2_lane1", 6'd2, 32'h0000_FF00, 4'h2, 0);
    rd_chk("dreg2_merge", 6'd2, 32'hA5A5_FFA5, 0);

    // INV and ADDA transforms
    wr_chk("ctrl_inv_adda", CTRL_A, 32'h0000_0300, 4'hF, 0);
    rd_chk("ctrl_inv_adda", CTRL_A, 32'h0000_0300, 0);
    wr_chk("dreg1_inv", 6'd1, 32'h0000_000F, 4'hF, 0);
    rd_chk("dreg1_adda", 6'd1, 32'hFFFF_FFF1, 0);
    rd_chk("dreg2_adda", 6'd2, 32'hA5A5_FFA7, 0);

    // WAIT=31 via lane 0 only; INV/ADDA lane stays masked
    wr_chk("ctrl_wait31", CTRL_A, 32'h0000_001F, 4'h1, 0);

    // Abort after 10 stall cycles: no count, FSM back to idle
    hi_cnt = 0;
    bus.avs_test_address = ACNT_A;
    bus.avs_test_read    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.avs_test_waitrequest) hi_cnt++;
    end
    @(posedge clk);
    #1;
    bus.avs_test_read = 1'b0;
    @(negedge clk);
    check("abort_stall_cycles", 32'(hi_cnt), 32'd10);
    check("idle_waitreq", 32'(bus.avs_test_waitrequest), 32'h0);
    @(posedge clk);
    #1;
    rd_chk("acnt_after_abort", ACNT_A, 32'd13, 31);
    rd_chk("ctrl_masked", CTRL_A, 32'h0000_031F, 31);
    wr_chk("ctrl_clear", CTRL_A, 32'h0000_0000, 4'h3, 31);

    // Read+write collision: read wins, ERR set, write dropped
    xfer(1'b1, 1'b1, 6'd0, 32'hDEAD_BEEF, 4'hF, r, w);
    check("rw_rdata", r, 32'h0000_0000);
    check("rw_wait", 32'(w), 32'd0);
    rd_chk("rw_dreg0_kept", 6'd0, 32'h0000_0000, 0);
    rd_chk("err_set", CTRL_A, 32'h0001_0000, 0);
    wr_chk("err_clr", CTRL_A, 32'h0001_0000, 4'h4, 0);
    rd_chk("err_cleared", CTRL_A, 32'h0000_0000, 0);

    // Out-of-map access completes and reads zero
    wr_chk("oom_write", 6'd40, 32'h1234_5678, 4'hF, 0);
    rd_chk("oom_read", 6'd40, 32'h0000_0000, 0);

    // ACNT wrap: pad the count to exactly 65536 with continuous zero-wait reads
    rd_chk("acnt_pre_wrap", ACNT_A, 32'd23, 0);
    n_hold = 65536 - exp_acnt;
    bus.avs_test_address = 6'd63;
    bus.avs_test_read    = 1'b1;
    repeat (n_hold) @(posedge clk);
    #1;
    bus.avs_test_read = 1'b0;
    rd_chk("acnt_wrapped", ACNT_A, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
